// File: rtl/rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// rx_frame_buffer
//
// Store-and-forward Ethernet receive buffer. Bytes arrive from the MAC on a
// byte-wide valid/ready stream. The 14-byte header (dst, src, length) is
// parsed into a shadow register, the frame is validated, and the payload is
// written speculatively into a FIFO. The payload becomes visible to the reader
// only when the whole frame turns out to be good (commit). A bad frame is
// rolled back so the reader never sees any of its bytes. Every drop pulses
// rx_err, latches a reason code and bumps a saturating drop counter.
//
// Optional feature macro: RX_ADDR_FILTER_EN
//   defined   -> frames whose dst is neither local_mac nor broadcast are
//                dropped with reason code 0.
//   undefined -> no address filtering; local_mac is present but unused.
//
// Parameters
//   FIFO_DEPTH  payload FIFO entries (power of two, >= 16)
//   MAX_LEN     largest legal length field
//   CNT_W       drop-counter width
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_axis_tdata     stream byte
//   r_valid, r_last   byte valid / final byte of frame
//   r_ready           byte accepted when r_valid && r_ready
//   local_mac         station address for the destination filter
//   rx_hdr_dst/src    header of the last committed frame
//   rx_hdr_len        length of the last committed frame
//   rx_header_valid   one-cycle pulse on commit
//   brx_rd_en         pop one payload byte
//   rx_data, rx_last  FIFO head (first-word-fall-through), end-of-frame flag
//   brx_empty         no committed data available
//   rx_err            one-cycle pulse on drop
//   rx_err_code       0 filter miss, 1 bad length / no space,
//                     2 length mismatch, 3 runt
//   rx_drop_cnt       saturating drop count
// -----------------------------------------------------------------------------
module rx_frame_buffer #(
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_LEN    = 1500,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_axis_tdata,
  input  logic             r_valid,
  input  logic             r_last,
  output logic             r_ready,
  input  logic [47:0]      local_mac,
  output logic [47:0]      rx_hdr_dst,
  output logic [47:0]      rx_hdr_src,
  output logic [15:0]      rx_hdr_len,
  output logic             rx_header_valid,
  input  logic             brx_rd_en,
  output logic [7:0]       rx_data,
  output logic             rx_last,
  output logic             brx_empty,
  output logic             rx_err,
  output logic [1:0]       rx_err_code,
  output logic [CNT_W-1:0] rx_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]    DEPTH_P   = PW'(FIFO_DEPTH);
  localparam logic [15:0]      MAX_LEN_L = 16'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // FIFO storage: each entry is {last, byte}
  logic [8:0] mem [FIFO_DEPTH];

  logic [PW-1:0]    wr_ptr_reg, wr_commit_reg, rd_ptr_reg;
  logic [3:0]       hdr_cnt_reg;
  logic [111:0]     hdr_sh_reg;      // {dst, src, len}, shifted in MSB-first
  logic [15:0]      rem_reg;
  logic             ready_reg;
  logic             hv_reg;
  logic             err_reg;
  logic [1:0]       err_code_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [47:0]      hdr_dst_reg, hdr_src_reg;
  logic [15:0]      hdr_len_reg;

  // Datapath strobes produced by the FSM output process
  logic       hdr_shift;
  logic       do_write;
  logic       do_commit;
  logic       do_rollback;
  logic       do_drop;
  logic [1:0] drop_code;
  logic       load_rem;

  logic        acc;
  logic        hdr_last_byte;
  logic        rem_one;
  logic [15:0] len_full;
  logic [PW-1:0] free_space;
  logic        len_bad;
  logic        filt_miss;

  assign acc           = r_valid && ready_reg;
  assign hdr_last_byte = (hdr_cnt_reg == 4'd13);
  assign rem_one       = (rem_reg == 16'd1);

  // Length is complete only together with the 14th byte itself
  assign len_full   = {hdr_sh_reg[7:0], rx_axis_tdata};
  // Room left for a new frame; uncommitted bytes never count as used
  assign free_space = DEPTH_P - (wr_commit_reg - rd_ptr_reg);
  assign len_bad    = (len_full == 16'd0) || (len_full > MAX_LEN_L) ||
                      (len_full > 16'(free_space));

`ifdef RX_ADDR_FILTER_EN
  // At the 14th byte the destination sits at these bits of the shadow
  logic [47:0] hdr_dst_cur;
  logic [5:0]  byte_match;
  logic [5:0]  byte_bcast;
  assign hdr_dst_cur = hdr_sh_reg[103:56];
  for (genvar gi = 0; gi < 6; gi++) begin : g_dst_cmp
    assign byte_match[gi] = (hdr_dst_cur[8*gi +: 8] == local_mac[8*gi +: 8]);
    assign byte_bcast[gi] = (hdr_dst_cur[8*gi +: 8] == 8'hFF);
  end
  assign filt_miss = !(&byte_match) && !(&byte_bcast);
`else
  logic unused_local_mac;
  assign unused_local_mac = ^local_mac;
  assign filt_miss        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_HDR;
    else        state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HDR: begin
        // A frame that ends on byte 14 returns straight to HDR either way
        if (acc && hdr_last_byte && !r_last) begin
          if (filt_miss || len_bad) state_next = ST_DROP;
          else                      state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (acc) begin
          if (rem_one && !r_last) state_next = ST_DROP;
          else if (rem_one || r_last) state_next = ST_HDR;
        end
      end
      ST_DROP: begin
        if (acc && r_last) state_next = ST_HDR;
      end
      default: state_next = ST_HDR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output (strobe) logic
  // ---------------------------------------------------------------------------
  always_comb begin
    hdr_shift   = 1'b0;
    do_write    = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    do_drop     = 1'b0;
    drop_code   = 2'd0;
    load_rem    = 1'b0;
    case (state_reg)
      ST_HDR: begin
        if (acc) begin
          hdr_shift = 1'b1;
          if (!hdr_last_byte) begin
            if (r_last) begin
              do_drop   = 1'b1;
              drop_code = 2'd3;
            end
          end else if (filt_miss) begin
            do_drop   = 1'b1;
            drop_code = 2'd0;
          end else if (len_bad) begin
            do_drop   = 1'b1;
            drop_code = 2'd1;
          end else if (r_last) begin
            // Header alone but a non-zero length promised
            do_drop   = 1'b1;
            drop_code = 2'd2;
          end else begin
            load_rem = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (acc) begin
          do_write = 1'b1;
          if (rem_one && r_last) begin
            do_commit = 1'b1;
          end else if (rem_one || r_last) begin
            do_drop     = 1'b1;
            drop_code   = 2'd2;
            do_rollback = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Payload memory: no reset so it maps onto block RAM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_reg[AW-1:0]] <= {rem_one, rx_axis_tdata};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      wr_commit_reg <= '0;
      rd_ptr_reg    <= '0;
      hdr_cnt_reg   <= '0;
      hdr_sh_reg    <= '0;
      rem_reg       <= '0;
      ready_reg     <= 1'b0;
      hv_reg        <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= 2'd0;
      drop_cnt_reg  <= '0;
      hdr_dst_reg   <= '0;
      hdr_src_reg   <= '0;
      hdr_len_reg   <= '0;
    end else begin
      ready_reg <= 1'b1;
      hv_reg    <= do_commit;
      err_reg   <= do_drop;

      // Header byte counter restarts at every frame boundary
      if (hdr_shift) begin
        hdr_sh_reg <= {hdr_sh_reg[103:0], rx_axis_tdata};
        if (r_last || hdr_last_byte) hdr_cnt_reg <= 4'd0;
        else                         hdr_cnt_reg <= hdr_cnt_reg + 4'd1;
      end

      if (load_rem)      rem_reg <= len_full;
      else if (do_write) rem_reg <= rem_reg - 16'd1;

      if (do_rollback)   wr_ptr_reg <= wr_commit_reg;
      else if (do_write) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;

      if (do_commit) begin
        wr_commit_reg <= wr_ptr_reg + PTR_ONE;
        hdr_dst_reg   <= hdr_sh_reg[111:64];
        hdr_src_reg   <= hdr_sh_reg[63:16];
        hdr_len_reg   <= hdr_sh_reg[15:0];
      end

      if (brx_rd_en && !brx_empty) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;

      if (do_drop) begin
        err_code_reg <= drop_code;
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [8:0] head;
  assign head = mem[rd_ptr_reg[AW-1:0]];

  assign brx_empty       = (rd_ptr_reg == wr_commit_reg);
  assign rx_data         = brx_empty ? 8'd0 : head[7:0];
  assign rx_last         = brx_empty ? 1'b0 : head[8];
  assign r_ready         = ready_reg;
  assign rx_header_valid = hv_reg;
  assign rx_err          = err_reg;
  assign rx_err_code     = err_code_reg;
  assign rx_drop_cnt     = drop_cnt_reg;
  assign rx_hdr_dst      = hdr_dst_reg;
  assign rx_hdr_src      = hdr_src_reg;
  assign rx_hdr_len      = hdr_len_reg;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_buffer
//
// Directed-vector bench for rx_frame_buffer. Frames are driven byte by byte,
// committed payload is popped and compared with hand-computed values, and
// drop reason codes / counter values are compared after each bad frame.
// The drop counter is built 3 bits wide here so saturation is reached.
// -----------------------------------------------------------------------------
module tb_rx_frame_buffer;

  localparam int CW = 3;
  localparam logic [47:0] LOCAL = 48'hAABBCCDDEEFF;
  localparam logic [47:0] SRC   = 48'h112233445566;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_axis_tdata;
  logic          r_valid;
  logic          r_last;
  logic          r_ready;
  logic [47:0]   local_mac;
  logic [47:0]   rx_hdr_dst;
  logic [47:0]   rx_hdr_src;
  logic [15:0]   rx_hdr_len;
  logic          rx_header_valid;
  logic          brx_rd_en;
  logic [7:0]    rx_data;
  logic          rx_last;
  logic          brx_empty;
  logic          rx_err;
  logic [1:0]    rx_err_code;
  logic [CW-1:0] rx_drop_cnt;

  rx_frame_buffer #(
    .FIFO_DEPTH(64),
    .MAX_LEN(1500),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_axis_tdata(rx_axis_tdata),
    .r_valid(r_valid),
    .r_last(r_last),
    .r_ready(r_ready),
    .local_mac(local_mac),
    .rx_hdr_dst(rx_hdr_dst),
    .rx_hdr_src(rx_hdr_src),
    .rx_hdr_len(rx_hdr_len),
    .rx_header_valid(rx_header_valid),
    .brx_rd_en(brx_rd_en),
    .rx_data(rx_data),
    .rx_last(rx_last),
    .brx_empty(brx_empty),
    .rx_err(rx_err),
    .rx_err_code(rx_err_code),
    .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int hv_seen = 0;
  int exp_drops = 0;
  logic [7:0] pay [0:31];

  // Pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_err)          err_seen++;
    if (rx_header_valid) hv_seen++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    rx_axis_tdata = d;
    r_valid       = 1'b1;
    r_last        = l;
    @(posedge clk);
    #1;
    r_valid = 1'b0;
    r_last  = 1'b0;
  endtask

  // Sends 14 header bytes then n_pay bytes from pay[]; r_last on the final
  // byte when end_last is set.
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] len,
                            input int n_pay, input logic end_last);
    logic [111:0] hdr;
    int total;
    hdr   = {dst, SRC, len};
    total = 14 + n_pay;
    for (int i = 0; i < total; i++) begin
      if (i < 14) send_byte(hdr[111-8*i -: 8], end_last && (i == total - 1));
      else        send_byte(pay[i-14], end_last && (i == total - 1));
    end
    $display("frame dst=%h len=%0d payload_bytes=%0d last=%0d", dst, len, n_pay, end_last);
  endtask

  // First n header bytes, r_last on the nth
  task automatic send_runt(input int n);
    logic [111:0] hdr;
    hdr = {LOCAL, SRC, 16'd10};
    for (int i = 0; i < n; i++) send_byte(hdr[111-8*i -: 8], i == n - 1);
    $display("runt header_bytes=%0d", n);
  endtask

  task automatic fill_pay(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) pay[i] = base + 8'(i);
  endtask

  task automatic read_byte(input string tag, input logic [7:0] d, input logic l);
    chk($sformatf("%s_nonempty", tag), brx_empty, 1'b0);
    chk($sformatf("%s_data", tag), rx_data, d);
    chk($sformatf("%s_last", tag), rx_last, l);
    brx_rd_en = 1'b1;
    @(posedge clk);
    #1;
    brx_rd_en = 1'b0;
  endtask

  task automatic read_frame(input string tag, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++)
      read_byte($sformatf("%s_b%0d", tag, i), base + 8'(i), i == n - 1);
    $display("read %s bytes=%0d", tag, n);
  endtask

  // Call after a bad frame; e0 is err_seen captured before the frame
  task automatic expect_drop(input string tag, input int e0, input logic [1:0] code);
    int sat;
    idle(2);
    exp_drops++;
    sat = (exp_drops > 7) ? 7 : exp_drops;
    chk($sformatf("%s_err_pulses", tag), 64'(err_seen - e0), 64'd1);
    chk($sformatf("%s_code", tag), rx_err_code, code);
    chk($sformatf("%s_cnt", tag), rx_drop_cnt, 64'(sat));
    chk($sformatf("%s_empty", tag), brx_empty, 1'b1);
  endtask

  task automatic check_reset_vals(input string p);
    chk($sformatf("%s_ready", p), r_ready, 1'b0);
    chk($sformatf("%s_hv", p), rx_header_valid, 1'b0);
    chk($sformatf("%s_err", p), rx_err, 1'b0);
    chk($sformatf("%s_code", p), rx_err_code, 2'd0);
    chk($sformatf("%s_cnt", p), rx_drop_cnt, 0);
    chk($sformatf("%s_dst", p), rx_hdr_dst, 0);
    chk($sformatf("%s_src", p), rx_hdr_src, 0);
    chk($sformatf("%s_len", p), rx_hdr_len, 0);
    chk($sformatf("%s_empty", p), brx_empty, 1'b1);
    chk($sformatf("%s_data", p), rx_data, 8'd0);
    chk($sformatf("%s_rlast", p), rx_last, 1'b0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!r_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, r_ready, 1'b1);
  endtask

  initial begin
    int e0;
    int h0;
    r_valid       = 1'b0;
    r_last        = 1'b0;
    rx_axis_tdata = 8'd0;
    brx_rd_en     = 1'b0;
    local_mac     = LOCAL;

    // Reset state
    idle(2);
    check_reset_vals("rst");
    rst_n = 1'b1;
    wait_ready("rst_ready");

    // Good unicast frame, len 10
    fill_pay(8'hA0, 10);
    h0 = hv_seen;
    send_frame(LOCAL, 16'd10, 10, 1'b1);
    chk("t1_hv", rx_header_valid, 1'b1);
    chk("t1_empty_now", brx_empty, 1'b0);
    chk("t1_len", rx_hdr_len, 16'd10);
    chk("t1_dst", rx_hdr_dst, LOCAL);
    chk("t1_src", rx_hdr_src, SRC);
    chk("t1_err", rx_err, 1'b0);
    idle(1);
    chk("t1_hv_drop", rx_header_valid, 1'b0);
    read_frame("t1", 8'hA0, 10);
    chk("t1_empty_end", brx_empty, 1'b1);
    chk("t1_hv_count", 64'(hv_seen - h0), 64'd1);

    // Pops while empty must be ignored
    brx_rd_en = 1'b1;
    idle(3);
    brx_rd_en = 1'b0;

    // Broadcast, len 1
    pay[0] = 8'h55;
    send_frame(BCAST, 16'd1, 1, 1'b1);
    chk("t2_hv", rx_header_valid, 1'b1);
    chk("t2_dst", rx_hdr_dst, BCAST);
    chk("t2_len", rx_hdr_len, 16'd1);
    read_frame("t2", 8'h55, 1);
    chk("t2_empty_end", brx_empty, 1'b1);

    // Foreign destination
    local_mac = 48'h0;
    pay[0] = 8'h77;
    e0 = err_seen;
    send_frame(48'h123456789ABC, 16'd1, 1, 1'b1);
`ifdef RX_ADDR_FILTER_EN
    expect_drop("t2_filter", e0, 2'd0);
`else
    chk("t2_nofilter_hv", rx_header_valid, 1'b1);
    read_frame("t2_nofilter", 8'h77, 1);
    chk("t2_nofilter_err", 64'(err_seen - e0), 64'd0);
`endif
    local_mac = LOCAL;

    // Early r_last inside payload
    fill_pay(8'hE0, 3);
    e0 = err_seen;
    send_frame(LOCAL, 16'd5, 3, 1'b1);
    expect_drop("t3_short", e0, 2'd2);
    fill_pay(8'hB0, 5);
    send_frame(LOCAL, 16'd5, 5, 1'b1);
    chk("t3_hv", rx_header_valid, 1'b1);
    read_frame("t3", 8'hB0, 5);

    // Payload longer than the length field
    fill_pay(8'hD0, 7);
    e0 = err_seen;
    h0 = hv_seen;
    send_frame(LOCAL, 16'd5, 7, 1'b1);
    expect_drop("t4_long", e0, 2'd2);
    chk("t4_no_hv", 64'(hv_seen - h0), 64'd0);
    fill_pay(8'hC0, 3);
    send_frame(LOCAL, 16'd3, 3, 1'b1);
    chk("t4_hv", rx_header_valid, 1'b1);
    chk("t4_len", rx_hdr_len, 16'd3);
    read_frame("t4", 8'hC0, 3);

    // Fill 60 bytes, then a frame that does not fit
    for (int k = 0; k < 6; k++) begin
      fill_pay(8'h10 * 8'(k + 1), 10);
      send_frame(LOCAL, 16'd10, 10, 1'b1);
    end
    fill_pay(8'hF0, 10);
    e0 = err_seen;
    send_frame(LOCAL, 16'd10, 10, 1'b1);
    idle(2);
    exp_drops++;
    chk("t5_err_pulses", 64'(err_seen - e0), 64'd1);
    chk("t5_code", rx_err_code, 2'd1);
    chk("t5_cnt", rx_drop_cnt, 64'((exp_drops > 7) ? 7 : exp_drops));
    for (int k = 0; k < 6; k++)
      read_frame($sformatf("t5_f%0d", k), 8'h10 * 8'(k + 1), 10);
    chk("t5_empty_mid", brx_empty, 1'b1);
    fill_pay(8'hF0, 10);
    send_frame(LOCAL, 16'd10, 10, 1'b1);
    chk("t5_hv", rx_header_valid, 1'b1);
    read_frame("t5_retry", 8'hF0, 10);

    // Length boundaries, all ending on header byte 14
    e0 = err_seen;
    send_frame(LOCAL, 16'd0, 0, 1'b1);
    expect_drop("len0", e0, 2'd1);
    e0 = err_seen;
    send_frame(LOCAL, 16'd1501, 0, 1'b1);
    expect_drop("len1501", e0, 2'd1);
    e0 = err_seen;
    send_frame(LOCAL, 16'd5, 0, 1'b1);
    expect_drop("hdr_only", e0, 2'd2);

    // Runts; the second pushes the 3-bit counter to saturation
    e0 = err_seen;
    send_runt(8);
    expect_drop("runt8", e0, 2'd3);
    e0 = err_seen;
    send_runt(13);
    expect_drop("runt13", e0, 2'd3);
    e0 = err_seen;
    send_runt(1);
    expect_drop("runt1", e0, 2'd3);

    // Max legal length passes the length check but cannot fit: code 1
    e0 = err_seen;
    send_frame(LOCAL, 16'd1500, 0, 1'b1);
    expect_drop("len1500", e0, 2'd1);

    // Reset in the middle of a payload with committed data waiting
    fill_pay(8'h90, 2);
    send_frame(LOCAL, 16'd2, 2, 1'b1);
    fill_pay(8'h80, 3);
    send_frame(LOCAL, 16'd10, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    idle(2);
    rst_n = 1'b1;
    exp_drops = 0;
    wait_ready("midrst_ready");
    chk("midrst_empty_after", brx_empty, 1'b1);
    fill_pay(8'h40, 4);
    send_frame(LOCAL, 16'd4, 4, 1'b1);
    chk("post_hv", rx_header_valid, 1'b1);
    chk("post_len", rx_hdr_len, 16'd4);
    read_frame("post", 8'h40, 4);
    chk("post_empty", brx_empty, 1'b1);
    chk("post_cnt", rx_drop_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_buffer.md
# rx_frame_buffer

Parametrised store-and-forward Ethernet frame receiver that sits between the MAC's byte-wide AXI-stream receive side and the payload consumer. Parses the 14-byte header (6 dst, 6 src, 2 length), validates each frame, and commits its payload to an internal FIFO only when the whole frame is good. Bad frames are rolled back so the reader never sees them. Drops are counted and reported with a reason code.

## Interface
- FIFO_DEPTH, 64, payload FIFO entries; power of two, ≥ 16
- MAX_LEN, 1500, largest legal length field
- CNT_W, 16, drop-counter width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- rx_axis_tdata  in  8  stream byte
- r_valid  in  1  byte valid
- r_last  in  1  final byte of frame
- r_ready  out  1  byte accepted when r_valid && r_ready
- local_mac  in  48  station address for filtering
- rx_hdr_dst / rx_hdr_src  out  48 each  header of last committed frame
- rx_hdr_len  out  16  length of last committed frame
- rx_header_valid  out  1  one-cycle pulse on commit
- brx_rd_en  in  1  pop payload byte
- rx_data  out  8  FIFO head (first-word-fall-through)
- rx_last  out  1  head byte is last payload byte of its frame
- brx_empty  out  1  no committed data
- rx_err  out  1  one-cycle pulse on drop
- rx_err_code  out  2  0 filter miss, 1 bad length/no space, 2 length mismatch, 3 runt
- rx_drop_cnt  out  CNT_W  saturating drop count

## Operation
- FIFO entry = {last, byte}; pointers log2(FIFO_DEPTH)+1 bits. wr_ptr (speculative), wr_commit, rd_ptr.
- States: HDR, PAYLOAD, DROP. Reset → HDR, byte counter 0.
- HDR: counts 14 accepted bytes MSB-first into shadow dst/src/len. r_last before byte 14 → drop, code 3, stay HDR.
- At byte 14 (len complete), checks in priority order: filter miss (dst ≠ local_mac and dst ≠ FF..FF) → code 0; len = 0 or len > MAX_LEN or len > free (FIFO_DEPTH − (wr_commit − rd_ptr)) → code 1. Failing frame: drop; DROP state unless byte 14 had r_last (then HDR). Passing: PAYLOAD, remaining = len. Byte 14 with r_last and passing checks → code 2 drop.
- PAYLOAD: each accepted byte written at wr_ptr, remaining decrements. Byte where remaining = 1 is written with last = 1:
  - r_last set → commit: wr_commit ← wr_ptr+1, shadow header → outputs, rx_header_valid pulse, → HDR.
  - r_last clear → code 2 drop, wr_ptr ← wr_commit, → DROP.
  - r_last on earlier byte → code 2 drop, rollback, → HDR.
- DROP: accept and discard until r_last, → HDR.
- Drop: rx_err pulse, rx_err_code held until next drop, rx_drop_cnt +1 saturating at all-ones.
- r_ready = 1 whenever out of reset; free-space check guarantees no overflow.
- Read: brx_empty = (rd_ptr == wr_commit); rd_ptr++ on brx_rd_en && !brx_empty; brx_rd_en while empty ignored.

## Timing
- Reset values: r_ready 0, rx_header_valid 0, rx_err 0, rx_err_code 0, rx_drop_cnt 0, headers 0, brx_empty 1, rx_data/rx_last 0 while empty.
- Commit on the edge accepting the last byte; next cycle brx_empty = 0 and rx_header_valid = 1 together.
- rx_data/rx_last reflect head combinationally from memory; pop effective at the edge.
- Simultaneous commit and pop: both apply; free space uses pre-edge wr_commit/rd_ptr.
- Reset mid-frame: all pointers, state and counters cleared; partial and committed data discarded.

## Configuration
- RX_ADDR_FILTER_EN defined: destination filter active as above.
- Undefined: filter check skipped, all addresses accepted, code 0 never produced; local_mac remains a port, unused.

## Test plan
- Frame dst AA..FF=local_mac, len 10, payload A0..A9 → one rx_header_valid, rx_hdr_len 10, reads A0..A9, rx_last only on A9, brx_empty returns 1.
- Broadcast dst, len 1, payload 55 → committed; local_mac 00.., dst 12:34:..:BC (filter on) → rx_err, code 0, count 1, brx_empty stays 1.
- len 5 with r_last on payload byte 3 → code 2, no data visible; following good len 5 frame B0..B4 reads intact.
- len 5, 7 payload bytes → code 2, extra bytes discarded until r_last; next frame parses correctly.
- FIFO holding 60 unread bytes, frame len 10 → code 1; after reading 60 bytes, same frame commits.
- r_last on header byte 8 → code 3; reset asserted mid-payload → all outputs back to reset values.
